// File: rtl/bcd_pkg.sv
// Shared types and constants for the 3-digit BCD countdown timer.
// Holds the FSM state encoding and the BCD digit limits.
package bcd_pkg;

    localparam int          BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // True when every nibble of a 3-digit preset is a legal BCD digit.
    function automatic logic bcd_valid(input logic [3*BCD_W-1:0] v);
        return (v[11:8] <= BCD_MAX) && (v[7:4] <= BCD_MAX) && (v[3:0] <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit; decrements when enabled and borrowed into,
// wrapping 0 -> 9 and passing the borrow to the next more significant digit.
module bcd_digit_down
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             aclr,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    input  logic             dec_en,
    input  logic             borrow_in,
    output logic             borrow_out,
    output logic [BCD_W-1:0] value
);

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec_en && borrow_in) begin
            value <= (value == '0) ? BCD_MAX : value - 1'b1;
        end
    end

    // Borrow ripples only through digits sitting at zero.
    assign borrow_out = borrow_in && (value == '0);

endmodule

// File: rtl/bcd_countdown_3_digits.sv
// Three-digit BCD countdown timer with load/start/stop control and a
// DIV-cycle prescaler between decrements.
module bcd_countdown_3_digits
    import bcd_pkg::*;
#(
    parameter int DIV = 5000000
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             load,
    input  logic             start,
    input  logic             stop,
    input  logic [11:0]      preset,
    output logic [BCD_W-1:0] d2,
    output logic [BCD_W-1:0] d1,
    output logic [BCD_W-1:0] d0,
    output logic             busy,
    output logic             done,
    output logic             preset_err,
    output state_t           state_dbg
);

    localparam int            PW      = $clog2(DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    state_t        state, state_nx;
    logic [PW-1:0] presc, presc_nx;
    logic          valid_load, stop_acc, start_acc, at_wrap, tick, last_tick;
    logic          b0, b1, all_zero;

    assign valid_load = load && bcd_valid(preset);
    // Any load request (even a rejected one) owns the control cycle.
    assign stop_acc   = !load && stop && (state == RUN);
    assign start_acc  = !load && start && (state == IDLE || state == PAUSE);
    assign at_wrap    = (presc == PRE_MAX);
    assign tick       = (state == RUN) && at_wrap && !valid_load && !stop_acc;
    assign last_tick  = tick && (d2 == '0) && (d1 == '0) && (d0 == 4'd1);

    bcd_digit_down u_d0 (
        .clk(clk), .aclr(aclr), .load(valid_load), .load_val(preset[3:0]),
        .dec_en(tick), .borrow_in(1'b1), .borrow_out(b0), .value(d0)
    );

    bcd_digit_down u_d1 (
        .clk(clk), .aclr(aclr), .load(valid_load), .load_val(preset[7:4]),
        .dec_en(tick), .borrow_in(b0), .borrow_out(b1), .value(d1)
    );

    // The hundreds borrow-out is set exactly when all three digits are zero.
    bcd_digit_down u_d2 (
        .clk(clk), .aclr(aclr), .load(valid_load), .load_val(preset[11:8]),
        .dec_en(tick), .borrow_in(b1), .borrow_out(all_zero), .value(d2)
    );

    always_comb begin
        state_nx = state;
        presc_nx = presc;
        if (valid_load) begin
            state_nx = IDLE;
            presc_nx = '0;
        end else begin
            case (state)
                RUN: begin
                    if (stop_acc) begin
                        state_nx = PAUSE;
                    end else if (at_wrap) begin
                        presc_nx = '0;
                        if (last_tick) state_nx = DONE;
                    end else begin
                        presc_nx = presc + 1'b1;
                    end
                end
                IDLE, PAUSE: begin
                    if (start_acc) begin
                        state_nx = all_zero ? DONE : RUN;
                        // Resuming from PAUSE keeps the partially elapsed period.
                        if (state == IDLE) presc_nx = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state      <= IDLE;
            presc      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            preset_err <= 1'b0;
        end else begin
            state      <= state_nx;
            presc      <= presc_nx;
            busy       <= (state_nx == RUN);
            done       <= (state_nx == DONE);
            preset_err <= load && !bcd_valid(preset);
        end
    end

    assign state_dbg = state;

endmodule

// File: doc/bcd_countdown_3_digits.md
BCD_COUNTDOWN_3_DIGITS -- requirements
Module: bcd_countdown_3_digits

Interface
REQ-001 The block SHALL take parameter DIV, default 5000000, giving the number of clk cycles per decrement (0.1 s at 50 MHz); legal range is 2 or more.
REQ-002 The block SHALL have port clk, input, width 1: rising-edge clock.
REQ-003 The block SHALL have port aclr, input, width 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port load, input, width 1: single-cycle request to load preset.
REQ-005 The block SHALL have port start, input, width 1: single-cycle request to begin or resume counting.
REQ-006 The block SHALL have port stop, input, width 1: single-cycle request to pause counting.
REQ-007 The block SHALL have port preset, input, width 12: three BCD digits. Bits [11:8] are hundreds, [7:4] are tens, [3:0] are units.
REQ-008 The block SHALL have ports d2, d1 and d0, outputs, width 4 each: current hundreds, tens and units digits, registered.
REQ-009 The block SHALL have port busy, output, width 1: high while in RUN.
REQ-010 The block SHALL have port done, output, width 1: high while in DONE.
REQ-011 The block SHALL have port preset_err, output, width 1: one-cycle pulse when a load is rejected.

Function
REQ-012 The FSM SHALL have four states: IDLE, RUN, PAUSE and DONE.
REQ-013 load SHALL be accepted in any state. If every preset nibble is 9 or less, the digits SHALL take preset on the next edge and the state SHALL become IDLE.
REQ-014 If any preset nibble is greater than 9, the digits and state SHALL remain unchanged and preset_err SHALL pulse for 1 cycle.
REQ-015 In IDLE or PAUSE, start SHALL move the state to RUN when the digits are not 000, and to DONE when the digits are 000.
REQ-016 start SHALL be ignored in RUN and in DONE.
REQ-017 In RUN, stop SHALL move the state to PAUSE; the digits and the prescaler value SHALL be held.
REQ-018 stop SHALL be ignored in IDLE, PAUSE and DONE.
REQ-019 Priority on the same cycle SHALL be load first, then stop, then start.
REQ-020 Prescaler: a counter from 0 to DIV-1, active only in RUN. Entering RUN from IDLE SHALL clear it to 0. Resuming from PAUSE SHALL continue from the held value.
REQ-021 A tick SHALL occur when the prescaler equals DIV-1 in RUN. On that edge the prescaler SHALL wrap to 0 and the 3-digit value SHALL decrement by 1 in BCD.
REQ-022 BCD decrement rule: a digit at 0 SHALL become 9 and borrow from the next digit. A digit at 1 to 9 SHALL decrement by 1. No digit SHALL ever hold a value from 10 to 15.
REQ-023 Latency: when start is accepted at edge k from IDLE, the first decrement SHALL be visible after edge k+DIV.
REQ-024 The tick edge that produces 000 SHALL also move the state to DONE, so done rises in the same cycle the digits read 000.
REQ-025 The count SHALL never wrap below 000.
REQ-026 DONE SHALL hold the digits at 000 and keep done high until load or aclr.
REQ-027 A tick coinciding with stop SHALL be suppressed: stop wins, and there is no decrement.
REQ-028 A tick coinciding with a valid load SHALL be suppressed: load wins.
REQ-029 busy and done SHALL be decoded from the registered state and SHALL never be high together.

Reset
REQ-030 While aclr is low, the block SHALL asynchronously force state IDLE, digits 000, prescaler 0, busy 0, done 0 and preset_err 0.
REQ-031 Deassertion of aclr mid-count SHALL leave the block in IDLE at 000; the pre-reset count SHALL NOT be resumed.

Structure
REQ-032 Shared package bcd_pkg SHALL hold the state encoding type, the BCD_MAX constant (9) and the BCD digit width constant (4).
REQ-033 One sub-module, bcd_digit_down, SHALL be instantiated three times. It is a single digit with ports clk, aclr, load, load_val, dec_en, borrow_in and borrow_out, chained from units to hundreds.
REQ-034 The prescaler width SHALL be the ceiling of log2(DIV), computed at elaboration.

Verification (DIV=4)
REQ-035 Load 0x012 then start -> after 4, 8 and 12 cycles the digits SHALL read 011, 010 and 009; after 48 cycles they SHALL read 000 with done=1 and busy=0.
REQ-036 Load 0x100 then start -> after 4 cycles the digits SHALL read 099 (double borrow); d2 SHALL read 0, d1 9, d0 9.
REQ-037 Load 0x050, start, stop after 6 cycles, wait 20, start -> the digits SHALL hold 049 during PAUSE; the next decrement to 048 SHALL come 2 cycles after resume.
REQ-038 In RUN, load 0x0A3 -> preset_err SHALL pulse once; the count SHALL continue undisturbed and the state SHALL remain RUN.
REQ-039 Load 0x000 then start -> done=1 on the next cycle and no tick SHALL ever occur; a later start SHALL be ignored and load 0x005 SHALL return the block to IDLE with done=0.
REQ-040 Pulse aclr low mid-RUN at 037 -> the digits SHALL be 000, the state IDLE, and busy and done 0 immediately; a later start SHALL go to DONE.
